uart_program_loader: RTL

UART_PROGRAM_LOADER -- requirements
Module: uart_program_loader

---
 rtl/uart_program_loader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uart_program_loader.sv
// UART (8N1) program loader: assembles received bytes little-endian into 32-bit
// words and writes them to consecutive instruction-memory word addresses.
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    input  logic                  load_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [2:0] bit_idx;
    logic [1:0] byte_idx;
    logic [7:0] shift;
    logic       break_wait;
    logic       we_q;
    logic       rx_meta, rx_sync, rx_prev;

    // Synchronizer resets to the idle line level so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the assembled word is a plain register (not a RAM), so it is safe to clear on reset.
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            shift      <= '0;
            break_wait <= 1'b0;
            we_q       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            frame_err  <= 1'b0;
        end else if (!load_en) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            break_wait <= 1'b0;
            we_q       <= 1'b0;
            mem_addr   <= '0;
            frame_err  <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (we_q) begin
                mem_addr <= mem_addr + ADDR_WIDTH'(1);
            end
            unique case (state)
                IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_BIT) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == LAST_CLK) begin
                        cnt     <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (break_wait) begin
                        // A broken stop bit holds here until the line returns to idle.
                        if (rx_sync) begin
                            break_wait <= 1'b0;
                            state      <= IDLE;
                        end
                    end else if (cnt == LAST_CLK) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            state                          <= IDLE;
                            mem_wdata[{byte_idx, 3'b000} +: 8] <= shift;
                            byte_idx                       <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                we_q <= 1'b1;
                            end
                        end else begin
                            frame_err  <= 1'b1;
                            break_wait <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gating with load_en keeps the strobe off the instant loading is disabled.
    assign mem_we = we_q & load_en;
    assign busy   = load_en & ((state != IDLE) | (byte_idx != 2'd0));

endmodule
